// File: rtl/traffic_light_controller_timed.sv
// traffic_light_controller_timed: timed NS/EW light FSM with yellow/all-red clearance; TLC_PED_EN adds a pedestrian walk phase
module traffic_light_controller_timed #(
  parameter int GREEN_MIN     = 4,
  parameter int GREEN_MAX     = 16,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 1,
  parameter int TW            = 8
`ifdef TLC_PED_EN
  , parameter int WALK_CYCLES = 6
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       NSCar,
  input  logic       EWCar,
`ifdef TLC_PED_EN
  input  logic       ped_req,
  output logic       ped_walk,
`endif
  output logic [2:0] NSLite,
  output logic [2:0] EWLite,
  output logic [2:0] phase
);
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    AR_TO_EW  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    AR_TO_NS  = 3'd5
`ifdef TLC_PED_EN
    , PED_WALK = 3'd6
`endif
  } state_t;
  localparam logic [TW-1:0] G_MIN  = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] G_MAX  = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] Y_END  = TW'(YELLOW_CYCLES - 1);
  localparam logic [TW-1:0] AR_END = TW'(ALLRED_CYCLES - 1);
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic ns_req_q, ns_req_d, ew_req_q, ew_req_d;
`ifdef TLC_PED_EN
  localparam logic [TW-1:0] W_END = TW'(WALK_CYCLES - 1);
  logic ped_pend_q, ped_pend_d, to_ew_q, to_ew_d;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      NS_GREEN:  if (ew_req_q && timer_q >= G_MIN && (!NSCar || timer_q >= G_MAX)) state_d = NS_YELLOW;
      NS_YELLOW: if (timer_q == Y_END) state_d = AR_TO_EW;
      EW_GREEN:  if (ns_req_q && timer_q >= G_MIN && (!EWCar || timer_q >= G_MAX)) state_d = EW_YELLOW;
      EW_YELLOW: if (timer_q == Y_END) state_d = AR_TO_NS;
`ifdef TLC_PED_EN
      AR_TO_EW:  if (timer_q == AR_END) state_d = ped_pend_q ? PED_WALK : EW_GREEN;
      AR_TO_NS:  if (timer_q == AR_END) state_d = ped_pend_q ? PED_WALK : NS_GREEN;
      PED_WALK:  if (timer_q == W_END) state_d = to_ew_q ? EW_GREEN : NS_GREEN;
`else
      AR_TO_EW:  if (timer_q == AR_END) state_d = EW_GREEN;
      AR_TO_NS:  if (timer_q == AR_END) state_d = NS_GREEN;
`endif
      default:   state_d = AR_TO_NS;
    endcase
    timer_d  = (state_d != state_q) ? '0 : (&timer_q) ? timer_q : timer_q + 1'b1;
    // entering its own green clears a latch and wins over a same-cycle sensor
    ns_req_d = (state_d != NS_GREEN) && (ns_req_q || (NSCar && state_q != NS_GREEN));
    ew_req_d = (state_d != EW_GREEN) && (ew_req_q || (EWCar && state_q != EW_GREEN));
`ifdef TLC_PED_EN
    ped_pend_d = (state_d == PED_WALK && state_q != PED_WALK) ? 1'b0 : ped_pend_q | ped_req;
    to_ew_d    = (state_q == AR_TO_EW) ? 1'b1 : (state_q == AR_TO_NS) ? 1'b0 : to_ew_q;
`endif
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= NS_GREEN;
      timer_q    <= '0;
      ns_req_q   <= 1'b0;
      ew_req_q   <= 1'b0;
`ifdef TLC_PED_EN
      ped_pend_q <= 1'b0;
      to_ew_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ns_req_q   <= ns_req_d;
      ew_req_q   <= ew_req_d;
`ifdef TLC_PED_EN
      ped_pend_q <= ped_pend_d;
      to_ew_q    <= to_ew_d;
`endif
    end
  end
  assign phase  = state_q;
  assign NSLite = (state_q == NS_GREEN) ? 3'b001 : (state_q == NS_YELLOW) ? 3'b010 : 3'b100;
  assign EWLite = (state_q == EW_GREEN) ? 3'b001 : (state_q == EW_YELLOW) ? 3'b010 : 3'b100;
`ifdef TLC_PED_EN
  assign ped_walk = (state_q == PED_WALK);
`endif
endmodule
